// File: rtl/srpt_fetch_scheduler.sv
// Turns ACTIVE fetch-queue entries into single-block DMA reads and completions into DBUFF_UPDATE entries.
// Accept->request 1 cycle, completion->update 1 cycle; stalls on tag exhaustion, dma_req_ready_i, and a held update.
module srpt_fetch_scheduler #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 3,
  parameter int BLOCK_BYTES     = 64
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             fetch_in_valid_i,
  input  logic [98:0]      fetch_in_data_i,
  output logic             fetch_in_ready_o,
  output logic             dma_req_valid_o,
  input  logic             dma_req_ready_i,
  output logic [TAG_W-1:0] dma_req_tag_o,
  output logic [8:0]       dma_req_dbuff_o,
  output logic [19:0]      dma_req_offset_o,
  output logic [6:0]       dma_req_len_o,
  input  logic             dma_cmpl_valid_i,
  input  logic [TAG_W-1:0] dma_cmpl_tag_i,
  output logic             dma_cmpl_ready_o,
  output logic             update_valid_o,
  input  logic             update_ready_i,
  output logic [98:0]      update_data_o,
  output logic [TAG_W:0]   outstanding_o
);

  typedef struct packed {
    logic [9:0]  rsvd_hi;
    logic [2:0]  prio;
    logic [19:0] granted;
    logic [19:0] dbuffered;
    logic [19:0] remaining;
    logic        rsvd_lo;
    logic [8:0]  dbuff_id;
    logic [15:0] rpc_id;
  } entry_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  localparam logic [2:0]     PRIO_ACTIVE  = 3'b101;
  localparam logic [2:0]     PRIO_DB_UPD  = 3'b001;
  localparam logic [TAG_W:0] MAX_CNT      = (TAG_W+1)'(MAX_OUTSTANDING);
  localparam logic [TAG_W:0] CNT_ONE      = (TAG_W+1)'(1);

  state_t                   state_q, state_d;
  entry_t                   fin;
  entry_t                   upd_d, upd_q;
  logic                     upd_vld_q;
  logic [MAX_OUTSTANDING-1:0] tag_busy_q;
  logic [TAG_W:0]           outstanding_q;
  logic [TAG_W-1:0]         free_tag;
  logic                     have_free;
  logic                     admissible, accept, cmpl_hs, cmpl_live;
  logic [6:0]               len_d;
  logic [20:0]              end_sum;
  logic [19:0]              end_d;
  logic [TAG_W-1:0]         req_tag_q;
  logic [8:0]               req_dbuff_q;
  logic [19:0]              req_offset_q;
  logic [6:0]               req_len_q;
  logic [15:0]              tbl_rpc   [MAX_OUTSTANDING];
  logic [8:0]               tbl_dbuff [MAX_OUTSTANDING];
  logic [19:0]              tbl_end   [MAX_OUTSTANDING];
  logic                     unused_fields;

  assign fin           = entry_t'(fetch_in_data_i);
  assign unused_fields = ^{fin.granted, fin.rsvd_hi, fin.rsvd_lo};

  // Bitmap is registered, so a tag freed this cycle is only visible next cycle.
  always_comb begin
    free_tag  = '0;
    have_free = 1'b0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!tag_busy_q[i]) begin
        have_free = 1'b1;
        free_tag  = TAG_W'(i);
      end
    end
  end

  assign admissible = fetch_in_valid_i && (fin.prio == PRIO_ACTIVE) && (fin.remaining != '0)
                      && have_free && (outstanding_q != MAX_CNT);
  assign len_d   = (fin.remaining > 20'(BLOCK_BYTES)) ? 7'(BLOCK_BYTES) : fin.remaining[6:0];
  assign end_sum = {1'b0, fin.dbuffered} + {14'd0, len_d};
  assign end_d   = end_sum[20] ? 20'hFFFFF : end_sum[19:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)          state_d = S_ISSUE;
      S_ISSUE: if (dma_req_ready_i) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Reset gates the combinational readies so every output is 0 while held in reset.
  always_comb begin
    fetch_in_ready_o = 1'b0;
    dma_req_valid_o  = 1'b0;
    case (state_q)
      S_IDLE:  fetch_in_ready_o = ap_rst_n && admissible;
      S_ISSUE: dma_req_valid_o  = 1'b1;
      default: ;
    endcase
  end

  assign accept           = fetch_in_ready_o;
  assign dma_cmpl_ready_o = ap_rst_n && (!upd_vld_q || update_ready_i);
  assign cmpl_hs          = dma_cmpl_valid_i && dma_cmpl_ready_o;
  assign cmpl_live        = cmpl_hs && tag_busy_q[dma_cmpl_tag_i];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tag_busy_q    <= '0;
      outstanding_q <= '0;
    end else begin
      if (accept)    tag_busy_q[free_tag]       <= 1'b1;
      if (cmpl_live) tag_busy_q[dma_cmpl_tag_i] <= 1'b0;
      case ({accept, cmpl_live})
        2'b10:   outstanding_q <= outstanding_q + CNT_ONE;
        2'b01:   outstanding_q <= outstanding_q - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      req_tag_q    <= '0;
      req_dbuff_q  <= '0;
      req_offset_q <= '0;
      req_len_q    <= '0;
    end else if (accept) begin
      req_tag_q    <= free_tag;
      req_dbuff_q  <= fin.dbuff_id;
      req_offset_q <= fin.dbuffered;
      req_len_q    <= len_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (accept) begin
      tbl_rpc[free_tag]   <= fin.rpc_id;
      tbl_dbuff[free_tag] <= fin.dbuff_id;
      tbl_end[free_tag]   <= end_d;
    end
  end

  always_comb begin
    upd_d           = '0;
    upd_d.rpc_id    = tbl_rpc[dma_cmpl_tag_i];
    upd_d.dbuff_id  = tbl_dbuff[dma_cmpl_tag_i];
    upd_d.dbuffered = tbl_end[dma_cmpl_tag_i];
    upd_d.prio      = PRIO_DB_UPD;
  end

  // Single-entry skid: completions of unallocated tags are swallowed without an update.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      upd_vld_q <= 1'b0;
      upd_q     <= '0;
    end else if (cmpl_live) begin
      upd_vld_q <= 1'b1;
      upd_q     <= upd_d;
    end else if (update_ready_i) begin
      upd_vld_q <= 1'b0;
    end
  end

  assign dma_req_tag_o    = req_tag_q;
  assign dma_req_dbuff_o  = req_dbuff_q;
  assign dma_req_offset_o = req_offset_q;
  assign dma_req_len_o    = req_len_q;
  assign update_valid_o   = upd_vld_q;
  assign update_data_o    = upd_q;
  assign outstanding_o    = outstanding_q;

endmodule

// File: tb/tb_srpt_fetch_scheduler.sv
// Bench for srpt_fetch_scheduler: vector table plus hand sequences, requests and updates checked via scoreboard queues.
module tb_srpt_fetch_scheduler;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        fetch_in_valid_i;
  logic [98:0] fetch_in_data_i;
  logic        fetch_in_ready_o;
  logic        dma_req_valid_o;
  logic        dma_req_ready_i;
  logic [2:0]  dma_req_tag_o;
  logic [8:0]  dma_req_dbuff_o;
  logic [19:0] dma_req_offset_o;
  logic [6:0]  dma_req_len_o;
  logic        dma_cmpl_valid_i;
  logic [2:0]  dma_cmpl_tag_i;
  logic        dma_cmpl_ready_o;
  logic        update_valid_o;
  logic        update_ready_i;
  logic [98:0] update_data_o;
  logic [3:0]  outstanding_o;

  srpt_fetch_scheduler #(.MAX_OUTSTANDING(8), .TAG_W(3), .BLOCK_BYTES(64)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .fetch_in_valid_i(fetch_in_valid_i), .fetch_in_data_i(fetch_in_data_i), .fetch_in_ready_o(fetch_in_ready_o),
    .dma_req_valid_o(dma_req_valid_o), .dma_req_ready_i(dma_req_ready_i), .dma_req_tag_o(dma_req_tag_o),
    .dma_req_dbuff_o(dma_req_dbuff_o), .dma_req_offset_o(dma_req_offset_o), .dma_req_len_o(dma_req_len_o),
    .dma_cmpl_valid_i(dma_cmpl_valid_i), .dma_cmpl_tag_i(dma_cmpl_tag_i), .dma_cmpl_ready_o(dma_cmpl_ready_o),
    .update_valid_o(update_valid_o), .update_ready_i(update_ready_i), .update_data_o(update_data_o),
    .outstanding_o(outstanding_o)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [2:0]  tag;
    logic [8:0]  dbuff;
    logic [19:0] off;
    logic [6:0]  len;
  } req_t;

  typedef struct {
    logic [15:0] rpc;
    logic [8:0]  dbuff;
    logic [19:0] rem;
    logic [19:0] dbf;
    logic [2:0]  prio;
    logic        acc;
    logic [6:0]  len;
    logic [19:0] endo;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  req_t        req_q [$];
  logic [98:0] upd_q [$];
  logic [7:0]  m_busy = '0;
  int          m_cnt = 0;
  logic [15:0] m_rpc   [8];
  logic [8:0]  m_dbuff [8];
  logic [19:0] m_end   [8];
  vec_t        vecs    [9];

  task automatic check(input string nm, input logic [98:0] act, input logic [98:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  function automatic logic [98:0] mk_entry(input logic [15:0] rpc, input logic [8:0] dbuff,
                                           input logic [19:0] rem, input logic [19:0] dbf, input logic [2:0] prio);
    logic [98:0] d;
    d         = '0;
    d[15:0]   = rpc;
    d[24:16]  = dbuff;
    d[25]     = 1'b1;
    d[45:26]  = rem;
    d[65:46]  = dbf;
    d[85:66]  = 20'h12345;
    d[88:86]  = prio;
    d[98:89]  = 10'h2AA;
    return d;
  endfunction

  function automatic logic [98:0] mk_update(input logic [15:0] rpc, input logic [8:0] dbuff, input logic [19:0] endo);
    logic [98:0] d;
    d        = '0;
    d[15:0]  = rpc;
    d[24:16] = dbuff;
    d[65:46] = endo;
    d[88:86] = 3'b001;
    return d;
  endfunction

  function automatic logic [6:0] exp_len(input logic [19:0] rem);
    return (rem > 20'd64) ? 7'd64 : rem[6:0];
  endfunction

  function automatic logic [19:0] exp_end(input logic [19:0] dbf, input logic [19:0] rem);
    logic [20:0] s;
    s = {1'b0, dbf} + {14'd0, exp_len(rem)};
    return s[20] ? 20'hFFFFF : s[19:0];
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic send_entry(input logic [15:0] rpc, input logic [8:0] dbuff, input logic [19:0] rem,
                            input logic [19:0] dbf, input logic [6:0] len, input logic [19:0] endo);
    int   t;
    int   waited;
    req_t r;
    fetch_in_valid_i = 1'b1;
    fetch_in_data_i  = mk_entry(rpc, dbuff, rem, dbf, 3'b101);
    #1;
    waited = 0;
    while (!fetch_in_ready_o && waited < 20) begin
      cyc(1);
      waited++;
    end
    t = lowest_free();
    if (!fetch_in_ready_o || t < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: fetch_in_ready_o=%0b after %0d cycles, expected 1", fetch_in_ready_o, waited);
      fetch_in_valid_i = 1'b0;
      return;
    end
    r.tag = 3'(t); r.dbuff = dbuff; r.off = dbf; r.len = len;
    req_q.push_back(r);
    m_busy[t] = 1'b1; m_rpc[t] = rpc; m_dbuff[t] = dbuff; m_end[t] = endo; m_cnt++;
    cyc(1);
    fetch_in_valid_i = 1'b0;
    check("req_valid_1cyc_after_accept", 99'(dma_req_valid_o), 99'(1));
    check("outstanding_after_accept", 99'(outstanding_o), 99'(m_cnt));
  endtask

  task automatic complete(input logic [2:0] tag);
    int   waited;
    logic live;
    dma_cmpl_valid_i = 1'b1;
    dma_cmpl_tag_i   = tag;
    #1;
    waited = 0;
    while (!dma_cmpl_ready_o && waited < 20) begin
      cyc(1);
      waited++;
    end
    if (!dma_cmpl_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL cmpl_timeout: dma_cmpl_ready_o=0 after %0d cycles, expected 1", waited);
      dma_cmpl_valid_i = 1'b0;
      return;
    end
    live = m_busy[tag];
    if (live) begin
      upd_q.push_back(mk_update(m_rpc[tag], m_dbuff[tag], m_end[tag]));
      m_busy[tag] = 1'b0;
      m_cnt--;
    end
    cyc(1);
    dma_cmpl_valid_i = 1'b0;
    check("update_valid_after_cmpl", 99'(update_valid_o), 99'(live));
    check("outstanding_after_cmpl", 99'(outstanding_o), 99'(m_cnt));
  endtask

  task automatic hold_reject(input logic [98:0] d, input int n);
    fetch_in_valid_i = 1'b1;
    fetch_in_data_i  = d;
    #1;
    for (int i = 0; i < n; i++) begin
      check("reject_ready", 99'(fetch_in_ready_o), 99'(0));
      check("reject_no_req", 99'(dma_req_valid_o), 99'(0));
      cyc(1);
    end
    fetch_in_valid_i = 1'b0;
  endtask

  // Scoreboard side: compare on each handshake that will complete at the coming rising edge.
  initial begin
    req_t        r;
    logic [98:0] u;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && dma_req_valid_o && dma_req_ready_i) begin
        if (req_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL req_unexpected: tag %0d issued, no request expected", dma_req_tag_o);
        end else begin
          r = req_q.pop_front();
          check("req_tag", 99'(dma_req_tag_o), 99'(r.tag));
          check("req_dbuff", 99'(dma_req_dbuff_o), 99'(r.dbuff));
          check("req_offset", 99'(dma_req_offset_o), 99'(r.off));
          check("req_len", 99'(dma_req_len_o), 99'(r.len));
        end
      end
      if (ap_rst_n && update_valid_o && update_ready_i) begin
        if (upd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL update_unexpected: data %0h, no update expected", update_data_o);
        end else begin
          u = upd_q.pop_front();
          check("update_data", update_data_o, u);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vecs[0] = '{16'd7,  9'd7,   20'd512,    20'd0,       3'b101, 1'b1, 7'd64, 20'd64};
    vecs[1] = '{16'd9,  9'd3,   20'd20,     20'd1280,    3'b101, 1'b1, 7'd20, 20'd1300};
    vecs[2] = '{16'd1,  9'd1,   20'd64,     20'd100,     3'b101, 1'b1, 7'd64, 20'd164};
    vecs[3] = '{16'd2,  9'd2,   20'd65,     20'd0,       3'b101, 1'b1, 7'd64, 20'd64};
    vecs[4] = '{16'd3,  9'd4,   20'd1,      20'd10,      3'b101, 1'b1, 7'd1,  20'd11};
    vecs[5] = '{16'd4,  9'd5,   20'd64,     20'hFFFF0,   3'b101, 1'b1, 7'd64, 20'hFFFFF};
    vecs[6] = '{16'd5,  9'd6,   20'd100,    20'd0,       3'b011, 1'b0, 7'd0,  20'd0};
    vecs[7] = '{16'd6,  9'd8,   20'd0,      20'd0,       3'b101, 1'b0, 7'd0,  20'd0};
    vecs[8] = '{16'd10, 9'd511, 20'hFFFFF,  20'hFFFBF,   3'b101, 1'b1, 7'd64, 20'hFFFFF};

    ap_rst_n         = 1'b0;
    fetch_in_valid_i = 1'b1;
    fetch_in_data_i  = mk_entry(16'd7, 9'd7, 20'd512, 20'd0, 3'b101);
    dma_req_ready_i  = 1'b1;
    dma_cmpl_valid_i = 1'b0;
    dma_cmpl_tag_i   = 3'd0;
    update_ready_i   = 1'b1;
    cyc(2);
    check("rst_fetch_ready", 99'(fetch_in_ready_o), 99'(0));
    check("rst_req_valid", 99'(dma_req_valid_o), 99'(0));
    check("rst_cmpl_ready", 99'(dma_cmpl_ready_o), 99'(0));
    check("rst_update_valid", 99'(update_valid_o), 99'(0));
    check("rst_update_data", update_data_o, 99'(0));
    check("rst_outstanding", 99'(outstanding_o), 99'(0));
    ap_rst_n         = 1'b1;
    fetch_in_valid_i = 1'b0;
    cyc(1);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].acc) begin
        t = lowest_free();
        send_entry(vecs[i].rpc, vecs[i].dbuff, vecs[i].rem, vecs[i].dbf, vecs[i].len, vecs[i].endo);
        cyc(1);
        complete(3'(t));
      end else begin
        hold_reject(mk_entry(vecs[i].rpc, vecs[i].dbuff, vecs[i].rem, vecs[i].dbf, vecs[i].prio), 5);
      end
    end

    // Fill all eight tags, then hold a ninth until tag 3 is freed.
    for (int i = 0; i < 8; i++)
      send_entry(16'(100 + i), 9'(i), 20'd200, 20'(i * 64), exp_len(20'd200), exp_end(20'(i * 64), 20'd200));
    cyc(1);
    fetch_in_valid_i = 1'b1;
    fetch_in_data_i  = mk_entry(16'd30, 9'd100, 20'd200, 20'd900, 3'b101);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("full_ready", 99'(fetch_in_ready_o), 99'(0));
      cyc(1);
    end
    check("full_outstanding", 99'(outstanding_o), 99'(8));
    dma_cmpl_valid_i = 1'b1;
    dma_cmpl_tag_i   = 3'd3;
    #1;
    check("freed_tag_not_same_cycle", 99'(fetch_in_ready_o), 99'(0));
    check("cmpl_ready_when_full", 99'(dma_cmpl_ready_o), 99'(1));
    upd_q.push_back(mk_update(m_rpc[3], m_dbuff[3], m_end[3]));
    m_busy[3] = 1'b0;
    m_cnt--;
    cyc(1);
    dma_cmpl_valid_i = 1'b0;
    #1;
    check("freed_tag_next_cycle", 99'(fetch_in_ready_o), 99'(1));
    send_entry(16'd30, 9'd100, 20'd200, 20'd900, 7'd64, 20'd964);
    cyc(1);
    for (int i = 0; i < 8; i++) complete(3'(i));

    // DMA request backpressure, then back-to-back accept.
    dma_req_ready_i = 1'b0;
    send_entry(16'd20, 9'd21, 20'd30, 20'd500, 7'd30, 20'd530);
    fetch_in_valid_i = 1'b1;
    fetch_in_data_i  = mk_entry(16'd22, 9'd23, 20'd100, 20'd0, 3'b101);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", 99'(dma_req_valid_o), 99'(1));
      check("stall_req_tag", 99'(dma_req_tag_o), 99'(0));
      check("stall_req_dbuff", 99'(dma_req_dbuff_o), 99'(21));
      check("stall_req_offset", 99'(dma_req_offset_o), 99'(500));
      check("stall_req_len", 99'(dma_req_len_o), 99'(30));
      check("stall_no_accept", 99'(fetch_in_ready_o), 99'(0));
      cyc(1);
    end
    dma_req_ready_i = 1'b1;
    cyc(1);
    check("b2b_accept_ready", 99'(fetch_in_ready_o), 99'(1));
    send_entry(16'd22, 9'd23, 20'd100, 20'd0, 7'd64, 20'd64);
    cyc(1);

    // Update backpressure stalls the second completion.
    update_ready_i = 1'b0;
    complete(3'd0);
    dma_cmpl_valid_i = 1'b1;
    dma_cmpl_tag_i   = 3'd1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("upd_stall_cmpl_ready", 99'(dma_cmpl_ready_o), 99'(0));
      check("upd_stall_valid", 99'(update_valid_o), 99'(1));
      check("upd_stall_data", update_data_o, mk_update(16'd20, 9'd21, 20'd530));
      cyc(1);
    end
    update_ready_i = 1'b1;
    #1;
    check("upd_drain_cmpl_ready", 99'(dma_cmpl_ready_o), 99'(1));
    upd_q.push_back(mk_update(16'd22, 9'd23, 20'd64));
    m_busy[1] = 1'b0;
    m_cnt--;
    cyc(1);
    dma_cmpl_valid_i = 1'b0;
    check("second_update_valid", 99'(update_valid_o), 99'(1));
    check("second_update_data", update_data_o, mk_update(16'd22, 9'd23, 20'd64));
    check("second_update_outstanding", 99'(outstanding_o), 99'(0));
    cyc(1);

    // Reset with four tags in flight.
    for (int i = 0; i < 4; i++)
      send_entry(16'(40 + i), 9'(50 + i), 20'd300, 20'(i * 64), 7'd64, 20'(i * 64 + 64));
    cyc(1);
    check("pre_reset_outstanding", 99'(outstanding_o), 99'(4));
    fetch_in_valid_i = 1'b1;
    fetch_in_data_i  = mk_entry(16'd60, 9'd61, 20'd100, 20'd0, 3'b101);
    ap_rst_n         = 1'b0;
    #1;
    check("midrst_fetch_ready", 99'(fetch_in_ready_o), 99'(0));
    check("midrst_req_valid", 99'(dma_req_valid_o), 99'(0));
    check("midrst_req_tag", 99'(dma_req_tag_o), 99'(0));
    check("midrst_req_dbuff", 99'(dma_req_dbuff_o), 99'(0));
    check("midrst_req_offset", 99'(dma_req_offset_o), 99'(0));
    check("midrst_req_len", 99'(dma_req_len_o), 99'(0));
    check("midrst_cmpl_ready", 99'(dma_cmpl_ready_o), 99'(0));
    check("midrst_update_valid", 99'(update_valid_o), 99'(0));
    check("midrst_update_data", update_data_o, 99'(0));
    check("midrst_outstanding", 99'(outstanding_o), 99'(0));
    cyc(2);
    ap_rst_n         = 1'b1;
    fetch_in_valid_i = 1'b0;
    m_busy           = '0;
    m_cnt            = 0;
    cyc(1);
    check("postrst_outstanding", 99'(outstanding_o), 99'(0));
    check("postrst_req_valid", 99'(dma_req_valid_o), 99'(0));
    complete(3'd2);
    cyc(2);
    check("stale_cmpl_no_update", 99'(update_valid_o), 99'(0));
    check("stale_cmpl_outstanding", 99'(outstanding_o), 99'(0));

    check("req_queue_empty", 99'(req_q.size()), 99'(0));
    check("upd_queue_empty", 99'(upd_q.size()), 99'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
